// File: rtl/finv_arb_pkg.sv
// Shared constants and types for the finv request arbiter.
package finv_arb_pkg;

  localparam int FINV_LAT  = 3;
  localparam int TAG_W_MAX = 3;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One slot of the in-flight pipe: issue valid plus the issuing requester.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
  } tag_slot_t;

endpackage

// File: rtl/finv_rr_pick.sv
// Combinational N-way picker: round-robin from ptr+1 when rr_mode, else lowest index wins.
module finv_rr_pick
  import finv_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int TW = tag_w(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [TW-1:0] ptr,
  input  logic          rr_mode,
  output logic [N-1:0]  grant,
  output logic [TW-1:0] grant_idx,
  output logic          grant_any
);

  always_comb begin : pick
    int          idx;
    logic [TW-1:0] idx_b;
    idx       = 0;
    idx_b     = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx   = rr_mode ? (int'(ptr) + 1 + k) % N : k;
      idx_b = TW'(idx);
      if (!grant_any && elig[idx_b]) begin
        grant[idx_b] = 1'b1;
        grant_idx    = idx_b;
        grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/finv_arbiter.sv
// Shares one fixed-latency finv pipe among N requesters; a tag pipe routes results back.
// Define FINV_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module finv_arbiter
  import finv_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = FINV_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [32*N-1:0] req_data,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [32*N-1:0] rsp_data,
  output logic [31:0]     finv_a,
  input  logic [31:0]     finv_s,
  output logic            busy
);

  localparam int TW = tag_w(N);

  logic            pending_reg   [N];
  logic            rsp_valid_reg [N];
  logic [31:0]     rsp_buf_reg   [N];
  logic [31:0]     req_word      [N];
  logic [N-1:0]    elig;
  logic [N-1:0]    grant;
  logic [N-1:0]    pipe_hit;
  logic [TW-1:0]   grant_idx;
  logic [TW-1:0]   ptr;
  logic            grant_any;
  logic            rr_mode;
  logic [31:0]     finv_a_reg;
  tag_slot_t       pipe_reg [LAT+1];

  finv_rr_pick #(.N(N), .TW(TW)) u_pick (
    .elig      (elig),
    .ptr       (ptr),
    .rr_mode   (rr_mode),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

`ifdef FINV_ARB_RR_EN
  logic [TW-1:0] ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= TW'(N-1);
    end else if (grant_any) begin
      ptr_reg <= grant_idx;
    end
  end

  assign ptr     = ptr_reg;
  assign rr_mode = 1'b1;
`else
  assign ptr     = '0;
  assign rr_mode = 1'b0;
`endif

  assign req_ready = grant;
  assign finv_a    = finv_a_reg;

  // finv_a holds its last operand when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finv_a_reg <= '0;
    end else if (grant_any) begin
      finv_a_reg <= req_word[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LAT; s++) pipe_reg[s] <= '0;
    end else begin
      pipe_reg[0].valid <= grant_any;
      pipe_reg[0].tag   <= TAG_W_MAX'(grant_idx);
      for (int s = 1; s <= LAT; s++) pipe_reg[s] <= pipe_reg[s-1];
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign req_word[gi]            = req_data[32*gi +: 32];
      assign rsp_data[32*gi +: 32]   = rsp_buf_reg[gi];
      assign rsp_valid[gi]           = rsp_valid_reg[gi];
      assign elig[gi]                = req_valid[gi] & ~pending_reg[gi];
      assign pipe_hit[gi]            = pipe_reg[LAT].valid &&
                                       (pipe_reg[LAT].tag == TAG_W_MAX'(gi));

      // pending guarantees the buffer is empty whenever a result lands here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_reg[gi]   <= 1'b0;
          rsp_valid_reg[gi] <= 1'b0;
          rsp_buf_reg[gi]   <= '0;
        end else begin
          if (grant[gi]) begin
            pending_reg[gi] <= 1'b1;
          end else if (rsp_valid_reg[gi] && rsp_ready[gi]) begin
            pending_reg[gi] <= 1'b0;
          end
          if (pipe_hit[gi]) begin
            rsp_valid_reg[gi] <= 1'b1;
            rsp_buf_reg[gi]   <= finv_s;
          end else if (rsp_ready[gi]) begin
            rsp_valid_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s <= LAT; s++) busy = busy | pipe_reg[s].valid;
    for (int i = 0; i < N; i++) busy = busy | rsp_valid_reg[i];
  end

endmodule

// File: tb/tb_finv_arbiter.sv
// Directed bench for finv_arbiter with an in-bench 3-stage finv stub computing s = ~a.
module tb_finv_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [32*N-1:0] rsp_data;
  logic [31:0]     finv_a;
  logic [31:0]     finv_s;
  logic            busy;

  logic [31:0] s1, s2, s3;
  logic [31:0] dval [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  finv_arbiter #(.N(N), .LAT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .finv_a    (finv_a),
    .finv_s    (finv_s),
    .busy      (busy)
  );

  // Stub finv: three register stages, no reset, like the real unit.
  always_ff @(posedge clk) begin
    s1 <= ~finv_a;
    s2 <= s1;
    s3 <= s2;
  end
  assign finv_s = s3;

  initial begin
    dval[0] = 32'h40000000;
    dval[1] = 32'h3F800000;
    dval[2] = 32'h40400000;
    dval[3] = 32'hBF000000;
  end
  assign req_data = {dval[3], dval[2], dval[1], dval[0]};

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic [3:0] rr;
    logic [3:0] exp_rdy;
    logic [3:0] exp_rsv;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

`ifdef FINV_ARB_RR_EN
  localparam logic [3:0] MODE_A = 4'h4;
  localparam logic [3:0] MODE_B = 4'h1;
`else
  localparam logic [3:0] MODE_A = 4'h1;
  localparam logic [3:0] MODE_B = 4'h4;
`endif

  task automatic add_vec(input logic rst, input logic [3:0] rv, input logic [3:0] rr,
                         input logic [3:0] rdy, input logic [3:0] rsv, input logic bsy);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rr = rr;
    v.exp_rdy = rdy; v.exp_rsv = rsv; v.exp_busy = bsy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int idx, output int n);
    n = 0;
    while (!rsp_valid[idx] && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] held;

    // All four requesters streaming, every response consumed at once.
    add_vec(1, 4'hF, 4'hF, 4'h1, 4'h0, 0);
    add_vec(0, 4'hF, 4'hF, 4'h2, 4'h0, 1);
    add_vec(0, 4'hF, 4'hF, 4'h4, 4'h0, 1);
    add_vec(0, 4'hF, 4'hF, 4'h8, 4'h0, 1);
    add_vec(0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
    add_vec(0, 4'hF, 4'hF, 4'h0, 4'h1, 1);
    add_vec(0, 4'hF, 4'hF, 4'h1, 4'h2, 1);
    add_vec(0, 4'hF, 4'hF, 4'h2, 4'h4, 1);
    add_vec(0, 4'hF, 4'hF, 4'h4, 4'h8, 1);
    add_vec(0, 4'hF, 4'hF, 4'h8, 4'h0, 1);
    add_vec(0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
    add_vec(0, 4'hF, 4'hF, 4'h0, 4'h1, 1);
    add_vec(0, 4'hF, 4'hF, 4'h1, 4'h2, 1);
    add_vec(0, 4'hF, 4'hF, 4'h2, 4'h4, 1);
    // Requester 0 never consumes: it stalls pending, others keep cycling.
    add_vec(1, 4'hF, 4'hE, 4'h1, 4'h0, 0);
    add_vec(0, 4'hF, 4'hE, 4'h2, 4'h0, 1);
    add_vec(0, 4'hF, 4'hE, 4'h4, 4'h0, 1);
    add_vec(0, 4'hF, 4'hE, 4'h8, 4'h0, 1);
    add_vec(0, 4'hF, 4'hE, 4'h0, 4'h0, 1);
    add_vec(0, 4'hF, 4'hE, 4'h0, 4'h1, 1);
    add_vec(0, 4'hF, 4'hE, 4'h0, 4'h3, 1);
    add_vec(0, 4'hF, 4'hE, 4'h2, 4'h5, 1);
    add_vec(0, 4'hF, 4'hE, 4'h4, 4'h9, 1);
    add_vec(0, 4'hF, 4'hE, 4'h8, 4'h1, 1);
    add_vec(0, 4'hF, 4'hE, 4'h0, 4'h1, 1);
    add_vec(0, 4'hF, 4'hE, 4'h0, 4'h1, 1);
    add_vec(0, 4'hF, 4'hE, 4'h0, 4'h3, 1);
    add_vec(0, 4'hF, 4'hE, 4'h2, 4'h5, 1);
    // Contention between 0 and 2 right after granting 1: the arbitration mode decides.
    add_vec(1, 4'h2, 4'hF, 4'h2, 4'h0, 0);
    add_vec(0, 4'h5, 4'hF, MODE_A, 4'h0, 1);
    add_vec(0, 4'h5, 4'hF, MODE_B, 4'h0, 1);
    add_vec(0, 4'h0, 4'hF, 4'h0, 4'h0, 1);
    add_vec(0, 4'h0, 4'hF, 4'h0, 4'h0, 1);
    add_vec(0, 4'h0, 4'hF, 4'h0, 4'h2, 1);
    add_vec(0, 4'h0, 4'hF, 4'h0, MODE_A, 1);
    add_vec(0, 4'h0, 4'hF, 4'h0, MODE_B, 1);
    add_vec(0, 4'h0, 4'hF, 4'h0, 4'h0, 0);

    // Reset state
    reset_dut();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_finv_a",    finv_a,         32'h0);
    chk("rst_rsp_data0", rsp_data[31:0],    32'h0);
    chk("rst_rsp_data3", rsp_data[127:96],  32'h0);

    // Table-driven cycle vectors
    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].rst) reset_dut();
      req_valid = vecs[r].rv;
      rsp_ready = vecs[r].rr;
      #1;
      chk($sformatf("vec%0d_req_ready", r), 32'(req_ready), 32'(vecs[r].exp_rdy));
      chk($sformatf("vec%0d_rsp_valid", r), 32'(rsp_valid), 32'(vecs[r].exp_rsv));
      chk($sformatf("vec%0d_busy", r),      32'(busy),      32'(vecs[r].exp_busy));
      for (int i = 0; i < N; i++) begin
        if (vecs[r].exp_rsv[i])
          chk($sformatf("vec%0d_rsp_data%0d", r, i), rsp_data[32*i +: 32], ~dval[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Single request latency and value
    reset_dut();
    req_valid = 4'b0010;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    wait_rsp(1, n);
    chk("single_latency", 32'(n), 32'd4);
    chk("single_rsp_data", rsp_data[63:32], 32'hC07FFFFF);
    tick();
    tick();
    chk("single_hold_valid", 32'(rsp_valid), 32'h2);
    chk("single_hold_data",  rsp_data[63:32], 32'hC07FFFFF);

    // Requester 2 holds its result for 10 cycles
    reset_dut();
    req_valid = 4'b0100;
    #1;
    chk("stall_first_ready", 32'(req_ready), 32'h4);
    tick();
    wait_rsp(2, n);
    chk("stall_latency", 32'(n), 32'd4);
    held = rsp_data[95:64];
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall_c%0d_ready", k), 32'(req_ready[2]), 32'h0);
      chk($sformatf("stall_c%0d_data", k),  rsp_data[95:64], held);
      tick();
    end
    rsp_ready = 4'b0100;
    #1;
    chk("stall_release_same_cycle_ready", 32'(req_ready), 32'h0);
    tick();
    rsp_ready = '0;
    #1;
    chk("stall_next_cycle_ready", 32'(req_ready), 32'h4);
    chk("stall_consumed_valid",   32'(rsp_valid), 32'h0);
    req_valid = '0;
    tick();

    // Reset in the middle of three operations
    reset_dut();
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #1;
    tick();
    tick();
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("mid_pre_reset_rsp_valid", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_reset_busy",      32'(busy),      32'h0);
    chk("mid_reset_finv_a",    finv_a,         32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("mid_flushed_c%0d", k), 32'(rsp_valid), 32'h0);
    end
    rsp_ready = '0;
    req_valid = 4'b1000;
    #1;
    chk("mid_new_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    wait_rsp(3, n);
    chk("mid_new_latency", 32'(n), 32'd4);
    chk("mid_new_data", rsp_data[127:96], ~dval[3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
